// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED status blocks: mode codes and the helper
// functions that derive step-counter sizing from the clock and step period.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'b00,
    MODE_ROT_R  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } led_mode_e;

  function automatic int tick_cycles(input int clk_hz, input int step_ms);
    return clk_hz / 1000 * step_ms;
  endfunction

  function automatic int cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

  // Terminal count for a speed setting; the period never drops below one cycle.
  function automatic int tick_term(input int ticks, input logic [1:0] speed);
    int period;
    period = ticks >> speed;
    if (period < 1) period = 1;
    return period - 1;
  endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Step timer: free-runs to a speed-scaled terminal count while enabled,
// otherwise holds at zero and passes single-step pulses through.
module led_tick_gen
  import led_sequencer_pkg::*;
#(
  parameter int TICK_CYCLES = 4,
  parameter int CNT_W       = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] speed_i,
  input  logic       step_i,
  output logic       adv_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, term;

  always_comb term = CNT_W'(tick_term(TICK_CYCLES, speed_i));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    adv_o = 1'b0;
    if (en_i) begin
      // >= rather than == so a speed raise mid-period fires at once instead of wrapping.
      if (cnt_q >= term) begin
        cnt_d = '0;
        adv_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      adv_o = step_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_sequencer.sv
// Board status LED pattern engine: rotate/bounce/blink patterns advanced by a
// speed-scaled step timer, with pause and single-step; registered pad drive.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int LED_NUM    = 3,
  parameter int CLK_HZ     = 27_000_000,
  parameter int STEP_MS    = 500,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               step,
  output logic [LED_NUM-1:0] led,
  output logic               tick
);

  localparam int TICK_CYCLES = tick_cycles(CLK_HZ, STEP_MS);
  localparam int CNT_W       = cnt_width(TICK_CYCLES);

  localparam logic [LED_NUM-1:0] PAT_ONE  = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] PAT_ALL  = '1;
  localparam logic [LED_NUM-1:0] PAT_NONE = '0;

  logic               adv;
  logic [LED_NUM-1:0] pat_q, pat_d;
  logic [LED_NUM-1:0] led_q;
  logic               dir_q, dir_d;
  logic               tick_q;
  logic               eff_dir;
  led_mode_e          mode_sel;

  led_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_tick_gen (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .en_i    (en),
    .speed_i (speed),
    .step_i  (step),
    .adv_o   (adv)
  );

  assign mode_sel = led_mode_e'(mode);

  // Rotate/blink ticks clear dir, so entering BOUNCE mid-row heads left and
  // entering at the MSB is forced right by the end-of-row check below.
  always_comb begin
    pat_d   = pat_q;
    dir_d   = dir_q;
    eff_dir = dir_q;
    if (adv) begin
      if (mode_sel != MODE_BLINK && !$onehot(pat_q)) begin
        pat_d = PAT_ONE;
        dir_d = 1'b0;
      end else begin
        case (mode_sel)
          MODE_ROT_L: begin
            pat_d = (pat_q << 1) | (pat_q >> (LED_NUM - 1));
            dir_d = 1'b0;
          end
          MODE_ROT_R: begin
            pat_d = (pat_q >> 1) | (pat_q << (LED_NUM - 1));
            dir_d = 1'b0;
          end
          MODE_BOUNCE: begin
            if (LED_NUM > 1) begin
              eff_dir = pat_q[LED_NUM-1] | (~pat_q[0] & dir_q);
              pat_d   = eff_dir ? (pat_q >> 1) : (pat_q << 1);
              dir_d   = pat_d[LED_NUM-1] | (~pat_d[0] & eff_dir);
            end else begin
              dir_d = 1'b0;
            end
          end
          default: begin
            pat_d = (pat_q == PAT_NONE) ? PAT_ALL : PAT_NONE;
            dir_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pat_q  <= PAT_ONE;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
      led_q  <= ACTIVE_LOW ? ~PAT_ONE : PAT_ONE;
    end else begin
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      tick_q <= adv;
      led_q  <= ACTIVE_LOW ? ~pat_d : pat_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: per-cycle vector table for the pattern
// modes plus hand-written step, step-ignored and speed-change sequences.
module tb_led_sequencer;

  localparam logic [1:0] ROTL = 2'b00;
  localparam logic [1:0] ROTR = 2'b01;
  localparam logic [1:0] BNC  = 2'b10;
  localparam logic [1:0] BLK  = 2'b11;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       step;
    logic [2:0] exp_led;
    logic       exp_tick;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       en      = 1'b0;
  logic [1:0] mode    = ROTL;
  logic [1:0] speed   = 2'd0;
  logic       step    = 1'b0;
  logic [2:0] led;
  logic       tick;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  led_sequencer #(
    .LED_NUM    (3),
    .CLK_HZ     (1000),
    .STEP_MS    (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .mode    (mode),
    .speed   (speed),
    .step    (step),
    .led     (led),
    .tick    (tick)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock edge, then settle so registered outputs are sampled off the edge.
  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic [1:0] s,
                     input logic st, input logic [2:0] l, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.speed = s; v.step = st;
    v.exp_led = l; v.exp_tick = t;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [1:0] s,
                       input logic st);
    sys_rst = r; en = e; mode = m; speed = s; step = st;
  endtask

  initial begin
    int n_ticks;

    // Reset held two cycles.
    add(1, 0, ROTL, 0, 0, 3'b110, 0);
    add(1, 0, ROTL, 0, 0, 3'b110, 0);
    // ROT_L, speed 0: tick every 4th edge.
    for (int k = 0; k < 3; k++) add(0, 1, ROTL, 0, 0, 3'b110, 0);
    add(0, 1, ROTL, 0, 0, 3'b101, 1);
    for (int k = 0; k < 3; k++) add(0, 1, ROTL, 0, 0, 3'b101, 0);
    add(0, 1, ROTL, 0, 0, 3'b011, 1);
    for (int k = 0; k < 3; k++) add(0, 1, ROTL, 0, 0, 3'b011, 0);
    add(0, 1, ROTL, 0, 0, 3'b110, 1);
    // ROT_R, speed 2: tick every edge.
    add(0, 1, ROTR, 2, 0, 3'b011, 1);
    add(0, 1, ROTR, 2, 0, 3'b101, 1);
    add(0, 1, ROTR, 2, 0, 3'b110, 1);
    // BOUNCE sweep from bit0: 010,100,010,001,...
    add(0, 1, BNC, 2, 0, 3'b101, 1);
    add(0, 1, BNC, 2, 0, 3'b011, 1);
    add(0, 1, BNC, 2, 0, 3'b101, 1);
    add(0, 1, BNC, 2, 0, 3'b110, 1);
    add(0, 1, BNC, 2, 0, 3'b101, 1);
    add(0, 1, BNC, 2, 0, 3'b011, 1);
    add(0, 1, BNC, 2, 0, 3'b101, 1);
    add(0, 1, BNC, 2, 0, 3'b110, 1);
    // BLINK from a one-hot pattern: all-off, all-on, all-off (active-low pads).
    add(0, 1, BLK, 2, 0, 3'b111, 1);
    add(0, 1, BLK, 2, 0, 3'b000, 1);
    add(0, 1, BLK, 2, 0, 3'b111, 1);
    // Leaving BLINK restarts at bit0, then rotates.
    add(0, 1, ROTL, 2, 0, 3'b110, 1);
    add(0, 1, ROTL, 2, 0, 3'b101, 1);
    add(0, 1, ROTL, 2, 0, 3'b011, 1);
    // Entering BOUNCE at the MSB must head right.
    add(0, 1, BNC, 2, 0, 3'b101, 1);
    // Reset mid-bounce wins over en, then counting restarts from zero.
    add(1, 1, BNC, 2, 0, 3'b110, 0);
    add(0, 1, BNC, 0, 0, 3'b110, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].speed, vecs[i].step);
      cycle();
      check($sformatf("row%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      check($sformatf("row%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
    end

    // Paused: only step pulses at cycles 10 and 20 advance the pattern.
    drive(1, 0, ROTL, 0, 0);
    cycle();
    n_ticks = 0;
    for (int c = 1; c <= 25; c++) begin
      drive(0, 0, ROTL, 0, (c == 10 || c == 20));
      cycle();
      if (tick === 1'b1) n_ticks++;
      check($sformatf("pause_c%0d_tick", c), 32'(tick), 32'(c == 10 || c == 20));
      if (c == 10) check("step1_led", 32'(led), 32'(3'b101));
      if (c == 20) check("step2_led", 32'(led), 32'(3'b011));
    end
    check("pause_tick_count", 32'(n_ticks), 32'd2);

    // en 0->1 with step held high: step ignored, first tick after 4 edges.
    for (int c = 1; c <= 4; c++) begin
      drive(0, 1, ROTL, 0, 1);
      cycle();
      check($sformatf("step_ign_c%0d_tick", c), 32'(tick), 32'(c == 4));
    end
    check("step_ign_led", 32'(led), 32'(3'b110));

    // Speed raised with cnt=2: the >= compare fires on the very next edge.
    drive(1, 0, ROTL, 0, 0);
    cycle();
    drive(0, 1, ROTL, 0, 0);
    cycle();
    cycle();
    check("spd_pre_tick", 32'(tick), 32'd0);
    drive(0, 1, ROTL, 2, 0);
    cycle();
    check("spd_chg_tick", 32'(tick), 32'd1);
    check("spd_chg_led", 32'(led), 32'(3'b101));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
